// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: core word length and
// the beat-count type reported by each stage.
package pipe_pkg;

    localparam int WORD_LEN = 32;

    typedef logic [1:0] occ_t;

    function automatic occ_t occ_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One beat-holding register: valid + control + payload. Load wins over clear;
// clearing drops valid and zeroes control but keeps the payload.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 4 * WORD_LEN
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            ctrl_d  = ld_ctrl;
            data_d  = ld_data;
        end else if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign ctrl  = ctrl_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register with valid/ready handshake, optional skid slot
// (registered in_ready) and a synchronous flush that squashes every held beat.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = 3,
    parameter int DATA_W  = 4 * WORD_LEN,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output occ_t              occupancy
);

    logic              m_valid, s_valid;
    logic [CTRL_W-1:0] m_ctrl,  s_ctrl;
    logic [DATA_W-1:0] m_data,  s_data;
    logic              acc, pop;
    logic              m_load, m_clear, m_from_skid, s_load, s_clear;

    always_comb begin
        acc         = in_valid & in_ready;
        pop         = m_valid & out_ready;
        m_load      = 1'b0;
        m_clear     = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clear     = 1'b0;
        if (flush) begin
            // An accepted beat is discarded; a popped one has already left.
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else if (pop) begin
            if (s_valid) begin
                m_load      = 1'b1;
                m_from_skid = 1'b1;
                s_load      = acc;
                s_clear     = !acc;
            end else begin
                m_load  = acc;
                m_clear = !acc;
            end
        end else if (!m_valid) begin
            m_load = acc;
        end else begin
            s_load = acc;
        end
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .nReset  (nReset),
        .load    (m_load),
        .clear   (m_clear),
        .ld_ctrl (m_from_skid ? s_ctrl : in_ctrl),
        .ld_data (m_from_skid ? s_data : in_data),
        .valid   (m_valid),
        .ctrl    (m_ctrl),
        .data    (m_data)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .nReset  (nReset),
                .load    (s_load),
                .clear   (s_clear),
                .ld_ctrl (in_ctrl),
                .ld_data (in_data),
                .valid   (s_valid),
                .ctrl    (s_ctrl),
                .data    (s_data)
            );
            assign in_ready = !s_valid;
        end else begin : g_noskid
            logic unused_skid_ctl;
            assign unused_skid_ctl = s_load ^ s_clear;
            assign s_valid  = 1'b0;
            assign s_ctrl   = '0;
            assign s_data   = '0;
            assign in_ready = !m_valid | out_ready;
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;
    assign occupancy = occ_count(m_valid, s_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid (index 0) and a no-skid (index 1) stage with shared stimulus;
// each is checked every cycle against a queue model plus directed literals.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = 3;
    localparam int DW = 128;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic [1:0]         in_ready_w, out_valid_w;
    logic [1:0][CW-1:0] out_ctrl_w;
    logic [1:0][DW-1:0] out_data_w;
    logic [1:0][1:0]    occ_w;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    function automatic void chk(input int dut, input string name,
                                input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL dut%0d %s: got %0h expected %0h at %0t", dut, name, act, exp, $time);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int SK = (gi == 0) ? 1 : 0;
        beat_t         mq[$];
        logic [DW-1:0] last_d = '0;

        pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(SK)) dut (
            .clk       (clk),
            .nReset    (nReset),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[gi]),
            .in_ctrl   (in_ctrl),
            .in_data   (in_data),
            .out_valid (out_valid_w[gi]),
            .out_ready (out_ready),
            .out_ctrl  (out_ctrl_w[gi]),
            .out_data  (out_data_w[gi]),
            .occupancy (occ_w[gi])
        );

        function automatic logic model_ready();
            if (SK != 0) return mq.size() < 2;
            return (mq.size() == 0) || out_ready;
        endfunction

        always @(posedge clk or negedge nReset) begin
            if (!nReset) begin
                mq.delete();
                last_d = '0;
            end else begin
                logic acc_m, pop_m;
                acc_m = in_valid && model_ready();
                pop_m = (mq.size() > 0) && out_ready;
                if (flush) begin
                    mq.delete();
                end else begin
                    if (pop_m) void'(mq.pop_front());
                    if (acc_m) mq.push_back(beat_t'({in_ctrl, in_data}));
                    if (mq.size() > 0) last_d = mq[0].d;
                end
            end
        end

        always @(negedge clk) begin
            beat_t f;
            f = (mq.size() > 0) ? mq[0] : '0;
            chk(gi, "out_valid", DW'(out_valid_w[gi]), DW'(mq.size() > 0));
            chk(gi, "out_ctrl",  DW'(out_ctrl_w[gi]),  DW'(f.c));
            chk(gi, "out_data",  out_data_w[gi], (mq.size() > 0) ? f.d : last_d);
            chk(gi, "occupancy", DW'(occ_w[gi]), DW'(mq.size()));
            chk(gi, "in_ready",  DW'(in_ready_w[gi]), DW'(model_ready()));
        end
    end

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst out_valid", DW'(out_valid_w[k]), '0);
            chk(k, "rst out_data",  out_data_w[k], '0);
            chk(k, "rst occupancy", DW'(occ_w[k]), '0);
            chk(k, "rst in_ready",  DW'(in_ready_w[k]), DW'(1));
        end
        nReset = 1'b1;

        // Streaming at full rate, one-cycle latency
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'b101, DW'(8'h11 + i), 1, 0);
            for (int k = 0; k < 2; k++) begin
                chk(k, "stream data", out_data_w[k], DW'(8'h11 + i));
                chk(k, "stream ctrl", DW'(out_ctrl_w[k]), DW'(3'b101));
            end
            chk(0, "stream occ", DW'(occ_w[0]), DW'(1));
        end
        drive(0, 0, 0, 1, 0);
        chk(0, "stream drained", DW'(occ_w[0]), '0);

        // Back-pressure into the skid slot
        drive(1, 1, DW'(8'hA1), 0, 0);
        chk(0, "bp occ1", DW'(occ_w[0]), DW'(1));
        drive(1, 1, DW'(8'hA2), 0, 0);
        chk(0, "bp occ2", DW'(occ_w[0]), DW'(2));
        chk(0, "bp in_ready", DW'(in_ready_w[0]), '0);
        drive(1, 1, DW'(8'hA3), 0, 0);
        chk(0, "bp hold A1", out_data_w[0], DW'(8'hA1));
        drive(1, 1, DW'(8'hA3), 1, 0);
        chk(0, "bp out A2", out_data_w[0], DW'(8'hA2));
        drive(1, 1, DW'(8'hA3), 1, 0);
        chk(0, "bp out A3", out_data_w[0], DW'(8'hA3));
        drive(0, 0, 0, 1, 0);
        chk(0, "bp idle ctrl", DW'(out_ctrl_w[0]), '0);
        chk(0, "bp idle data held", out_data_w[0], DW'(8'hA3));

        // Flush while full with a beat offered
        drive(1, 2, DW'(8'hB1), 0, 0);
        drive(1, 2, DW'(8'hB2), 0, 0);
        chk(0, "pre-flush occ", DW'(occ_w[0]), DW'(2));
        drive(1, 2, DW'(8'hB3), 0, 1);
        for (int k = 0; k < 2; k++) begin
            chk(k, "flush out_valid", DW'(out_valid_w[k]), '0);
            chk(k, "flush out_ctrl",  DW'(out_ctrl_w[k]), '0);
            chk(k, "flush occ",       DW'(occ_w[k]), '0);
        end
        drive(0, 0, 0, 1, 0);
        chk(0, "flush beat absent", DW'(out_valid_w[0]), '0);

        // Asynchronous reset mid-stream, between clock edges
        drive(1, 6, DW'(16'hBEEF), 1, 0);
        chk(0, "beef loaded", out_data_w[0], DW'(16'hBEEF));
        nReset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k, "async rst valid", DW'(out_valid_w[k]), '0);
            chk(k, "async rst data",  out_data_w[k], '0);
        end
        #1;
        nReset   = 1'b1;
        in_valid = 1'b0;
        #1;
        chk(0, "post-rst in_ready", DW'(in_ready_w[0]), DW'(1));
        chk(1, "post-rst in_ready", DW'(in_ready_w[1]), DW'(1));
        drive(1, 6, DW'(16'hBEEF), 1, 0);
        chk(0, "first accept", out_data_w[0], DW'(16'hBEEF));

        // Combinational in_ready of the single-slot variant
        drive(1, 2, DW'(8'hC1), 0, 0);
        chk(1, "noskid in_ready low", DW'(in_ready_w[1]), '0);
        out_ready = 1'b1;
        #1;
        chk(1, "noskid in_ready high", DW'(in_ready_w[1]), DW'(1));
        drive(1, 2, DW'(8'hC2), 1, 0);
        chk(1, "noskid C2", out_data_w[1], DW'(8'hC2));
        drive(1, 2, DW'(8'hC3), 1, 0);
        chk(1, "noskid C3", out_data_w[1], DW'(8'hC3));
        drive(0, 0, 0, 1, 0);

        // Random traffic against the queue model
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), CW'($urandom), DW'({$urandom, $urandom}),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
